// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle between the burst reader, its byte FIFO and the word sink.
interface fifo_burst_reader_if;
  logic        start;
  logic [6:0]  burst_len;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_read_en;
  logic [31:0] word_out;
  logic [3:0]  word_byte_en;
  logic        word_valid;
  logic        word_ready;
  logic        word_last;
  logic        busy;
  logic        done;

  modport master (
    output start, burst_len, fifo_empty, fifo_data, word_ready,
    input  fifo_read_en, word_out, word_byte_en, word_valid, word_last, busy, done
  );

  modport slave (
    input  start, burst_len, fifo_empty, fifo_data, word_ready,
    output fifo_read_en, word_out, word_byte_en, word_valid, word_last, busy, done
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops a burst of bytes from a 64x8 FIFO and packs them little-endian into
// 32-bit words with lane enables, a last flag and a valid/ready handshake.
module fifo_burst_reader #(
  parameter int unsigned MAX_BURST = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_burst_reader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [6:0] MAX_LEN = 7'(MAX_BURST);

  state_t      state;
  logic [6:0]  req_left;
  logic [6:0]  rcv_left;
  logic        inflight;
  logic [2:0]  lanes;
  logic [31:0] asm_data;
  logic        asm_pending;
  logic [31:0] word_q;
  logic [3:0]  be_q;
  logic        valid_q;
  logic        last_q;
  logic        done_q;

  logic        can_xfer;
  logic        cap_complete;
  logic        emit;
  logic        rd_en;
  logic [2:0]  lanes_next;
  logic [2:0]  out_count;
  logic [3:0]  slots;
  logic [6:0]  rcv_next;
  logic [6:0]  len_clamped;
  logic [31:0] asm_next;
  logic [3:0]  be_calc;

  always_comb begin
    can_xfer     = !valid_q || bus.word_ready;
    cap_complete = inflight && (lanes == 3'd3 || rcv_left == 7'd1);
    emit         = (cap_complete || asm_pending) && can_xfer;
    lanes_next   = lanes + {2'b00, inflight};
    rcv_next     = rcv_left - {6'b000000, inflight};
    out_count    = cap_complete ? lanes_next : lanes;
    slots        = {1'b0, lanes} + {3'b000, inflight};
    len_clamped  = (bus.burst_len > MAX_LEN) ? MAX_LEN : bus.burst_len;

    asm_next = asm_data;
    if (inflight) asm_next[{lanes[1:0], 3'b000} +: 8] = bus.fifo_data;

    case (out_count)
      3'd1:    be_calc = 4'b0001;
      3'd2:    be_calc = 4'b0011;
      3'd3:    be_calc = 4'b0111;
      default: be_calc = 4'b1111;
    endcase

    // A word finishing this edge and moving straight to the output frees all
    // four lanes, so the next request may overlap it to keep 1 byte/cycle.
    rd_en = (state == READ) && !bus.fifo_empty && (req_left != '0) &&
            ((slots < 4'd4) || (cap_complete && can_xfer));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_left    <= '0;
      rcv_left    <= '0;
      inflight    <= 1'b0;
      lanes       <= '0;
      asm_data    <= '0;
      asm_pending <= 1'b0;
      word_q      <= '0;
      be_q        <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= rd_en;
      if (rd_en)    req_left <= req_left - 7'd1;
      if (inflight) rcv_left <= rcv_next;
      if (valid_q && bus.word_ready) valid_q <= 1'b0;

      if (emit) begin
        word_q      <= asm_next;
        be_q        <= be_calc;
        last_q      <= (rcv_next == '0);
        valid_q     <= 1'b1;
        lanes       <= '0;
        asm_data    <= '0;
        asm_pending <= 1'b0;
      end else if (inflight) begin
        asm_data <= asm_next;
        lanes    <= lanes_next;
        if (cap_complete) asm_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.start && bus.burst_len != '0) begin
            state    <= READ;
            req_left <= len_clamped;
            rcv_left <= len_clamped;
          end
        end
        READ: begin
          if (rd_en && req_left == 7'd1) state <= DRAIN;
        end
        DRAIN: begin
          if (valid_q && bus.word_ready && last_q) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fifo_read_en = rd_en;
  assign bus.word_out     = word_q;
  assign bus.word_byte_en = be_q;
  assign bus.word_valid   = valid_q;
  assign bus.word_last    = last_q;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed and randomized bursts against a queue-based FIFO and word scoreboard.
module tb_fifo_burst_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_burst_reader_if ifc();

  fifo_burst_reader #(.MAX_BURST(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } word_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  word_t      exp_q[$];
  logic [7:0] pend;
  bit         pend_valid = 0;
  int         nreads = 0, done_cnt = 0, words_seen = 0, cyc = 0;
  int         first_rd = 0, last_rd = 0;
  int         ready_mode = 0;
  bit         toggle_empty = 0;
  int         stall_left = 0;
  bit         stall_used = 0;
  int         reads_at_unstall = 0;
  word_t      prev_w;
  bit         prev_valid = 0, prev_ready = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pend_valid) begin
      ifc.fifo_data = pend;
      pend_valid = 0;
    end
    cyc++;
    ifc.fifo_empty = (q.size() == 0) || (toggle_empty && cyc[1]);
    case (ready_mode)
      0: ifc.word_ready = 1'b1;
      1: ifc.word_ready = 1'($urandom_range(0, 1));
      default: begin
        if (!stall_used && ifc.word_valid) begin
          stall_used = 1;
          stall_left = 10;
        end
        if (stall_left > 0) begin
          ifc.word_ready = 1'b0;
          stall_left--;
          if (stall_left == 0) reads_at_unstall = nreads;
        end else begin
          ifc.word_ready = 1'b1;
        end
      end
    endcase
    @(negedge clk);
    if (ifc.fifo_read_en) begin
      chk("rd_while_empty", 64'(ifc.fifo_empty), 64'd0);
      if (q.size() > 0) begin
        pend = q.pop_front();
        pend_valid = 1;
      end
      if (nreads == 0) first_rd = cyc;
      last_rd = cyc;
      nreads++;
    end
    if (prev_valid && !prev_ready)
      chk("hold_stable", {ifc.word_valid, ifc.word_out, ifc.word_byte_en, ifc.word_last},
          {1'b1, prev_w});
    if (ifc.word_valid && ifc.word_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL word_extra observed=%0h expected=none", ifc.word_out);
      end else begin
        chk($sformatf("word%0d", words_seen),
            64'({ifc.word_out, ifc.word_byte_en, ifc.word_last}), 64'(exp_q.pop_front()));
      end
      words_seen++;
    end
    if (ifc.done) done_cnt++;
    prev_valid = ifc.word_valid;
    prev_ready = ifc.word_ready;
    prev_w     = {ifc.word_out, ifc.word_byte_en, ifc.word_last};
  endtask

  task automatic fill(input int n, input bit seq);
    for (int i = 0; i < n; i++) q.push_back(seq ? 8'(i + 1) : 8'($urandom));
  endtask

  task automatic start_burst(input int len);
    int n;
    word_t w;
    n = (len > 64) ? 64 : len;
    for (int i = 0; i < n; i += 4) begin
      w = '0;
      for (int j = 0; j < 4 && i + j < n; j++) begin
        w.data[8*j +: 8] = q[i + j];
        w.be[j] = 1'b1;
      end
      w.last = (i + 4 >= n);
      exp_q.push_back(w);
    end
    nreads = 0;
    done_cnt = 0;
    words_seen = 0;
    ifc.burst_len = 7'(len);
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
  endtask

  task automatic finish_burst(input int exp_reads);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) step();
    step();
    step();
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("read_count", 64'(nreads), 64'(exp_reads));
    chk("words_left", 64'(exp_q.size()), 64'd0);
    chk("busy_after", 64'(ifc.busy), 64'd0);
  endtask

  function automatic logic [44:0] outs();
    return {ifc.fifo_read_en, ifc.word_out, ifc.word_byte_en, ifc.word_valid,
            ifc.word_last, ifc.busy, ifc.done};
  endfunction

  initial begin
    int n, len;
    ifc.start = 1'b0;
    ifc.burst_len = '0;
    ifc.fifo_empty = 1'b1;
    ifc.fifo_data = '0;
    ifc.word_ready = 1'b1;

    step();
    chk("reset_outputs", 64'(outs()), 64'd0);
    rst_n = 1'b1;
    step();

    // 8-byte burst, full words, back-to-back reads
    fill(8, 1);
    start_burst(8);
    finish_burst(8);
    chk("rd_backtoback", 64'(last_rd - first_rd + 1), 64'd8);

    // 6-byte burst ending in a two-lane word
    fill(6, 1);
    start_burst(6);
    finish_burst(6);

    // downstream stall of 10 cycles after first word
    fill(16, 1);
    ready_mode = 2;
    stall_used = 0;
    start_burst(16);
    finish_burst(16);
    chk("reads_during_stall", 64'(reads_at_unstall), 64'd8);
    ready_mode = 0;

    // FIFO empty toggling every two cycles
    fill(12, 1);
    toggle_empty = 1;
    start_burst(12);
    finish_burst(12);
    toggle_empty = 0;

    // zero length is ignored
    start_burst(0);
    repeat (4) step();
    chk("len0_busy", 64'(ifc.busy), 64'd0);
    chk("len0_reads", 64'(nreads), 64'd0);
    chk("len0_done", 64'(done_cnt), 64'd0);

    // oversize length clamps to 64
    fill(64, 0);
    start_burst(100);
    finish_burst(64);
    chk("clamp_words", 64'(words_seen), 64'd16);
    chk("fifo_drained", 64'(q.size()), 64'd0);

    // reset mid-burst
    fill(12, 1);
    start_burst(12);
    for (int k = 0; k < 100 && nreads < 3; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(outs()), 64'd0);
    q.delete();
    exp_q.delete();
    pend_valid = 0;
    prev_valid = 0;
    step();
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("idle_after_reset", 64'(ifc.busy), 64'd0);
    fill(8, 0);
    start_burst(8);
    finish_burst(8);

    // randomized bursts with random backpressure and FIFO gaps, stray start mid-burst
    ready_mode = 1;
    for (int b = 0; b < 6; b++) begin
      len = $urandom_range(9, 90);
      n = (len > 64) ? 64 : len;
      fill(n, 0);
      toggle_empty = 1'($urandom_range(0, 1));
      start_burst(len);
      repeat (3) step();
      ifc.burst_len = 7'($urandom_range(1, 127));
      ifc.start = 1'b1;
      step();
      ifc.start = 1'b0;
      finish_burst(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
